// File: rtl/seg_scan_display.sv
// Multiplexed hex seven-segment scanner: one digit is enabled at a time for DIV clocks.
// Registered outputs support busy, per-digit blanking, decimal points and leading-zero suppression.
module seg_scan_display #(
   parameter int DIGITS         = 8,
   parameter int DIV            = 10000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic                  lz_en,
   input  logic                  busy,
   output logic [DIGITS-1:0]     led_en,
   output logic                  led_ca,
   output logic                  led_cb,
   output logic                  led_cc,
   output logic                  led_cd,
   output logic                  led_ce,
   output logic                  led_cf,
   output logic                  led_cg,
   output logic                  led_dp
);

   localparam int   DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int   IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);

   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    scan_idx;
   logic [4*DIGITS-1:0] shadow;
   logic                tick;

   logic [DIGITS-1:0]   upper_zero;
   logic [DIGITS-1:0]   en_next;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic                cur_lz;
   logic [6:0]          lit_next;
   logic                dp_next;
   logic [6:0]          seg_drive;
   logic                dp_drive;

   // Lit segments packed as {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'b0111111;
         4'h1: g = 7'b0000110;
         4'h2: g = 7'b1011011;
         4'h3: g = 7'b1001111;
         4'h4: g = 7'b1100110;
         4'h5: g = 7'b1101101;
         4'h6: g = 7'b1111101;
         4'h7: g = 7'b0000111;
         4'h8: g = 7'b1111111;
         4'h9: g = 7'b1101111;
         4'hA: g = 7'b1110111;
         4'hB: g = 7'b1111100;
         4'hC: g = 7'b0111001;
         4'hD: g = 7'b1011110;
         4'hE: g = 7'b1111001;
         4'hF: g = 7'b1110001;
      endcase
      return g;
   endfunction

   assign tick = (div_cnt == DIV_W'(DIV - 1));

   // upper_zero[i] is set when nibbles i..DIGITS-1 of the shadow are all zero.
   always_comb begin
      upper_zero             = '0;
      upper_zero[DIGITS-1]   = (shadow[4*DIGITS-1 -: 4] == 4'h0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         upper_zero[i] = upper_zero[i+1] && (shadow[4*i +: 4] == 4'h0);
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_lz    = 1'b0;
      en_next   = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx == IDX_W'(i)) begin
            cur_nib    = shadow[4*i +: 4];
            cur_dp     = dp_mask[i];
            cur_blank  = blank_mask[i];
            cur_lz     = lz_en && (i > 0) && upper_zero[i];
            en_next[i] = 1'b0;
         end
      end
   end

   // Busy wins over blanking, which wins over leading-zero suppression.
   always_comb begin
      lit_next = 7'b0000000;
      dp_next  = 1'b0;
      if (busy) begin
         lit_next = 7'b1000000;
      end else if (!cur_blank && !cur_lz) begin
         lit_next = hex_glyph(cur_nib);
         dp_next  = cur_dp;
      end
   end

   assign seg_drive = lit_next ^ {7{SEG_OFF}};
   assign dp_drive  = dp_next ^ SEG_OFF;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         scan_idx <= '0;
         shadow   <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) begin
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
         end
         if (load) begin
            shadow <= data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_en <= '1;
         {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} <= {7{SEG_OFF}};
         led_dp <= SEG_OFF;
      end else begin
         led_en <= en_next;
         {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} <= seg_drive;
         led_dp <= dp_drive;
      end
   end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning the number of multiplexed digits (legal range 1..16).
REQ-002 SHALL have parameter DIV, default 10000, meaning the number of clk cycles each digit stays enabled (legal range 2 or more).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning 1 drives a lit segment as 0 and 0 drives a lit segment as 1; led_en is always active-low.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, the reset; synchronous, active-low.
REQ-006 SHALL have port data, input, 4*DIGITS bits, the hex value to show; nibble i drives digit i, and nibble 0 is data[3:0].
REQ-007 SHALL have port load, input, 1 bit, a strobe that captures data into the shadow register.
REQ-008 SHALL have port dp_mask, input, DIGITS bits, per-digit decimal-point request (sampled live, not shadowed).
REQ-009 SHALL have port blank_mask, input, DIGITS bits, per-digit forced blank (sampled live).
REQ-010 SHALL have port lz_en, input, 1 bit, leading-zero suppression enable.
REQ-011 SHALL have port busy, input, 1 bit, which shows "-" on all digits while high.
REQ-012 SHALL have port led_en, output, DIGITS bits, digit enables, active-low, at most one bit low at a time.
REQ-013 SHALL have ports led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg and led_dp, outputs, 1 bit each, segment drives with polarity per SEG_ACTIVE_LOW.

Function
REQ-014 SHALL hold a divider counter div_cnt that counts 0..DIV-1 and wraps to 0; tick is true in the cycle where div_cnt==DIV-1.
REQ-015 SHALL hold a scan index scan_idx that advances by 1 on tick and wraps from DIGITS-1 to 0.
REQ-016 SHALL load shadow from data on the edge where load=1; shadow holds its value otherwise; load does not disturb div_cnt or scan_idx.
REQ-017 SHALL register all outputs, so outputs reflect the scan_idx, shadow, masks, lz_en and busy values present one cycle earlier (latency 1).
REQ-018 SHALL drive led_en as all ones except bit scan_idx, which is 0.
REQ-019 SHALL take the segment pattern for digit i from the first matching rule, in this priority:
  - busy=1: segment g only.
  - blank_mask[i]=1: all segments off, dp off.
  - lz_en=1, i>0, and nibbles i..DIGITS-1 of shadow all zero: all segments off, dp off.
  - otherwise: hex glyph of nibble i.
REQ-020 SHALL use these hex glyphs, listed as lit segments: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-021 SHALL light dp for digit i iff dp_mask[i]=1, busy=0 and the digit is not blanked by REQ-019.
REQ-022 SHALL, when load and tick occur in the same cycle, advance scan_idx and update shadow, with the new digit showing the new shadow one cycle later.
REQ-023 SHALL, with DIGITS=1, keep scan_idx at 0 and led_en at 0 permanently after reset.
REQ-024 SHALL never suppress digit 0 by lz_en, so a value of 0 shows a single "0".

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, clear div_cnt, scan_idx and shadow to 0.
REQ-026 SHALL, on that same reset edge, set led_en to all ones and drive all segments and dp to their off level.
REQ-027 SHALL clear state the same way when reset is asserted mid-scan, with no partial digit glitch afterwards: the first post-reset output update enables digit 0.
REQ-028 SHALL, on the first edge after rst_n rises, drive led_en=...1110 with glyph "0" (shadow=0).

Verification (DIGITS=8, DIV=4, SEG_ACTIVE_LOW=1)
REQ-029 Reset scan check:
  - Stimulus: reset, then run 40 cycles.
  - Response: led_en steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, with each value held exactly 4 cycles; every digit shows "0" (ca..cf=0, cg=1).
REQ-030 Load and glyph check:
  - Stimulus: load=1 for 1 cycle with data=0x89ABCDEF.
  - Response: digit0=F (ca,ce,cf,cg low), digit3=C, digit7=8 (all seg low); the shadow persists after data changes to 0.
REQ-031 Leading-zero check:
  - Stimulus: load data=0x00000120 with lz_en=1.
  - Response: digits 3..7 are all segments off, and digits 0..2 show 0, 2, 1.
  - Stimulus: then load data=0.
  - Response: only digit 0 shows "0".
REQ-032 Priority check:
  - Stimulus: busy=1, blank_mask=0x01, dp_mask=0xFF.
  - Response: every digit shows cg=0, other segments 1, dp=1 (off).
  - Stimulus: busy=0.
  - Response: digit 0 is fully off including dp; other digits light dp (led_dp=0).
REQ-033 Mid-scan reset check:
  - Stimulus: rst_n=0 for 1 cycle while scan_idx=5.
  - Response: next output is led_en=FF with all segments off, then FE with "0"; the shadow is cleared.
